// File: rtl/uart_pkg.sv
// Shared types for the configurable UART receiver.
//   parity_e   : parity mode encoding (matches the PARITY parameter values)
//   rx_state_e : receiver FSM states
//   majority3  : 2-of-3 vote used by the bit sampler
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ODD  = 2'd1,
        EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_WAIT_HI
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input conditioning for the UART receiver.
//   clk, rst  : clock, synchronous active-high reset
//   rx        : raw asynchronous line
//   sample_en : capture the synchronised line into the vote history
//   rx_s      : 2-flop synchronised line (reset to idle-high)
//   bit_vote  : majority of the two captured samples and the current rx_s
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rx,
    input  logic sample_en,
    output logic rx_s,
    output logic bit_vote
);

    logic       sync1_reg;
    logic       rx_s_reg;
    logic [1:0] hist_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            rx_s_reg  <= 1'b1;
            hist_reg  <= 2'b00;
        end else begin
            sync1_reg <= rx;
            rx_s_reg  <= sync1_reg;
            if (sample_en) begin
                hist_reg <= {hist_reg[0], rx_s_reg};
            end
        end
    end

    assign rx_s = rx_s_reg;
    // The third sample is the live rx_s, so the vote is ready on the
    // same cycle the bit counter reaches zero.
    assign bit_vote = majority3(hist_reg[1], hist_reg[0], rx_s_reg);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (data width, parity, stop bits) with
// majority-vote sampling, false-start rejection, parity/framing/break/
// overrun detection and a valid/ready output holding register.
//   clk, rst     : clock, synchronous active-high reset
//   rx           : asynchronous serial input, idle high
//   data_out     : received word (LSB first on the line)
//   data_valid   : word held until data_ready accepts it
//   data_ready   : consumer accept
//   parity_err   : parity status of the held word
//   frame_err    : a stop bit of the held word was low
//   break_det    : one-cycle pulse on a break frame
//   overrun_err  : one-cycle pulse when a word is dropped
//   busy         : FSM not idle
//   leds         : last accepted word, fitted to 8 bits
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun_err,
    output logic                 busy,
    output logic [7:0]           leds
);

    if (BAUD_DIV < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2
        || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
        $error("uart_rx_cfg: illegal parameter combination");
    end

    localparam int             CW         = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]  CNT_BIT    = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0]  CNT_START  = CW'(BAUD_DIV / 2 + 1);
    localparam logic [3:0]     LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0]     LAST_STOP  = 4'(STOP_BITS - 1);
    localparam parity_e        PAR_MODE   = parity_e'(PARITY[1:0]);
    localparam logic           HAS_PARITY = (PAR_MODE != NONE);
    localparam logic           PAR_IS_ODD = (PAR_MODE == ODD);

    rx_state_e              state_reg, state_next;
    logic [CW-1:0]          cnt_reg;
    logic [3:0]             bit_idx_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   par_bit_reg;
    logic                   stop_first_reg;
    logic                   frame_bad_reg;
    logic [DATA_BITS-1:0]   data_out_reg;
    logic                   data_valid_reg;
    logic                   parity_err_reg;
    logic                   frame_err_reg;
    logic                   break_reg;
    logic                   overrun_reg;
    logic [7:0]             leds_reg;
    logic [7:0]             leds_next;

    logic rx_s, bit_vote;
    logic active, bit_done, sample_en, frame_end;
    logic first_stop, stop_low_any, is_break, par_err_calc, consumer_free;

    assign active    = (state_reg == ST_START) || (state_reg == ST_DATA)
                    || (state_reg == ST_PAR)   || (state_reg == ST_STOP);
    assign bit_done  = active && (cnt_reg == '0);
    assign sample_en = active && ((cnt_reg == CW'(2)) || (cnt_reg == CW'(1)));
    assign frame_end = (state_reg == ST_STOP) && bit_done && (bit_idx_reg == LAST_STOP);

    // At frame end the current vote is the last stop bit; fold it in
    // with what earlier stop bits left behind.
    assign first_stop    = (bit_idx_reg == 4'd0) ? bit_vote : stop_first_reg;
    assign stop_low_any  = frame_bad_reg | ~bit_vote;
    assign is_break      = (shift_reg == '0) && !(HAS_PARITY && par_bit_reg) && !first_stop;
    assign par_err_calc  = HAS_PARITY && ((^shift_reg ^ par_bit_reg) != PAR_IS_ODD);
    assign consumer_free = !data_valid_reg || data_ready;

    uart_rx_sampler u_sampler (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .sample_en (sample_en),
        .rx_s      (rx_s),
        .bit_vote  (bit_vote)
    );

    // Narrow words are zero-extended onto the LEDs, wide ones truncated.
    for (genvar gi = 0; gi < 8; gi++) begin : g_leds
        if (gi < DATA_BITS) begin : g_bit
            assign leds_next[gi] = data_out_reg[gi];
        end else begin : g_zero
            assign leds_next[gi] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (!rx_s) state_next = ST_START;
            ST_START:   if (bit_done) state_next = bit_vote ? ST_IDLE : ST_DATA;
            ST_DATA:    if (bit_done && (bit_idx_reg == LAST_DATA))
                            state_next = HAS_PARITY ? ST_PAR : ST_STOP;
            ST_PAR:     if (bit_done) state_next = ST_STOP;
            ST_STOP:    if (frame_end)
                            state_next = (is_break || !bit_vote) ? ST_WAIT_HI : ST_IDLE;
            ST_WAIT_HI: if (rx_s) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            par_bit_reg    <= 1'b0;
            stop_first_reg <= 1'b0;
            frame_bad_reg  <= 1'b0;
            data_out_reg   <= '0;
            data_valid_reg <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            break_reg      <= 1'b0;
            overrun_reg    <= 1'b0;
            leds_reg       <= '0;
        end else begin
            break_reg   <= 1'b0;
            overrun_reg <= 1'b0;

            if (state_reg == ST_IDLE) begin
                bit_idx_reg   <= '0;
                frame_bad_reg <= 1'b0;
                if (!rx_s) begin
                    cnt_reg <= CNT_START;
                end
            end else if (active) begin
                cnt_reg <= bit_done ? CNT_BIT : cnt_reg - CW'(1);
            end

            if (bit_done) begin
                case (state_reg)
                    ST_DATA: begin
                        shift_reg   <= {bit_vote, shift_reg[DATA_BITS-1:1]};
                        bit_idx_reg <= (bit_idx_reg == LAST_DATA) ? 4'd0 : bit_idx_reg + 4'd1;
                    end
                    ST_PAR: begin
                        par_bit_reg <= bit_vote;
                        bit_idx_reg <= 4'd0;
                    end
                    ST_STOP: begin
                        if (bit_idx_reg == 4'd0) begin
                            stop_first_reg <= bit_vote;
                        end
                        frame_bad_reg <= stop_low_any;
                        bit_idx_reg   <= frame_end ? 4'd0 : bit_idx_reg + 4'd1;
                    end
                    default: bit_idx_reg <= 4'd0;
                endcase
            end

            // Accept first; a same-cycle new word below re-raises valid.
            if (data_valid_reg && data_ready) begin
                data_valid_reg <= 1'b0;
                leds_reg       <= leds_next;
            end

            if (frame_end) begin
                if (is_break) begin
                    break_reg <= 1'b1;
                end else if (consumer_free) begin
                    data_out_reg   <= shift_reg;
                    parity_err_reg <= par_err_calc;
                    frame_err_reg  <= stop_low_any;
                    data_valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end
        end
    end

    assign data_out    = data_out_reg;
    assign data_valid  = data_valid_reg;
    assign parity_err  = parity_err_reg;
    assign frame_err   = frame_err_reg;
    assign break_det   = break_reg;
    assign overrun_err = overrun_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign leds        = leds_reg;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench: DUT A is 8N1, DUT B is 7E2, both at 16 clocks per bit.
module tb_uart_rx_cfg;

    localparam int BAUD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a, rx_b, data_ready_a, data_ready_b;
    logic [7:0] data_out_a, leds_a, leds_b;
    logic [6:0] data_out_b;
    logic       data_valid_a, parity_err_a, frame_err_a, break_det_a, overrun_err_a, busy_a;
    logic       data_valid_b, parity_err_b, frame_err_b, break_det_b, overrun_err_b, busy_b;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    // monitor state
    int          rise_cyc_a, rise_cyc_b, dv_cnt_a, brk_cnt_a, ovr_cnt_a;
    logic        dv_prev_a = 1'b0, dv_prev_b = 1'b0;
    logic [11:0] words_a[$];
    logic [11:0] words_b[$];

    uart_rx_cfg #(.BAUD_DIV(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .data_out(data_out_a), .data_valid(data_valid_a),
        .data_ready(data_ready_a), .parity_err(parity_err_a), .frame_err(frame_err_a),
        .break_det(break_det_a), .overrun_err(overrun_err_a), .busy(busy_a), .leds(leds_a)
    );

    uart_rx_cfg #(.BAUD_DIV(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .data_out(data_out_b), .data_valid(data_valid_b),
        .data_ready(data_ready_b), .parity_err(parity_err_b), .frame_err(frame_err_b),
        .break_det(break_det_b), .overrun_err(overrun_err_b), .busy(busy_b), .leds(leds_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid_a && !dv_prev_a) rise_cyc_a = cyc;
        dv_prev_a = data_valid_a;
        if (data_valid_a) dv_cnt_a++;
        if (data_valid_a && data_ready_a)
            words_a.push_back({1'b0, frame_err_a, parity_err_a, 1'b0, data_out_a});
        if (break_det_a) brk_cnt_a++;
        if (overrun_err_a) ovr_cnt_a++;
        if (data_valid_b && !dv_prev_b) rise_cyc_b = cyc;
        dv_prev_b = data_valid_b;
        if (data_valid_b && data_ready_b)
            words_b.push_back({1'b0, frame_err_b, parity_err_b, 2'b00, data_out_b});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d required < 200000", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drive_rx(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    // spike_j >= 0 inverts the line for one clock at that offset in the bit
    task automatic send_bit(input bit sel, input logic v, input int spike_j);
        for (int j = 0; j < BAUD; j++) begin
            drive_rx(sel, (j == spike_j) ? ~v : v);
            step();
        end
    endtask

    task automatic send_frame(input bit sel, input logic [8:0] data, input int nbits,
                              input bit has_par, input logic par, input logic stop0,
                              input logic stop1, input int nstop, input int spike_bit);
        $display("frame dut=%s data=0x%0h bits=%0d par=%0d stops=%b%b spike_bit=%0d",
                 sel ? "B" : "A", data, nbits, has_par, stop0, stop1, spike_bit);
        send_bit(sel, 1'b0, -1);
        for (int i = 0; i < nbits; i++)
            send_bit(sel, data[i], (i == spike_bit) ? BAUD / 2 + 1 : -1);
        if (has_par) send_bit(sel, par, -1);
        send_bit(sel, stop0, -1);
        if (nstop == 2) send_bit(sel, stop1, -1);
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; data_ready_a = 1'b1; data_ready_b = 1'b1;
        steps(3);
        n_vec++; if ({data_valid_a, busy_a, parity_err_a, frame_err_a, break_det_a, overrun_err_a} !== 6'b0) begin
            n_bad++; $display("FAIL reset_flags_a: got %b required 000000",
                {data_valid_a, busy_a, parity_err_a, frame_err_a, break_det_a, overrun_err_a}); end
        n_vec++; if ({data_out_a, leds_a} !== 16'h0000) begin
            n_bad++; $display("FAIL reset_data_a: got %h required 0000", {data_out_a, leds_a}); end
        n_vec++; if ({data_valid_b, busy_b, data_out_b, leds_b} !== 17'h0) begin
            n_bad++; $display("FAIL reset_b: got %h required 0", {data_valid_b, busy_b, data_out_b, leds_b}); end
        rst = 1'b0;
        steps(4);
        n_vec++; if (busy_a !== 1'b0) begin
            n_bad++; $display("FAIL idle_busy_a: got %b required 0", busy_a); end
    endtask

    task automatic test_timing_8n1();
        int fall_cyc, dv0;
        logic [11:0] got;
        words_a.delete();
        dv0 = dv_cnt_a;
        fall_cyc = cyc;
        send_frame(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1);
        steps(4);
        // first clock edge that samples rx low is cycle 0
        n_vec++; if (rise_cyc_a - (fall_cyc + 1) !== 2 + (BAUD / 2 + 2) + 9 * BAUD) begin
            n_bad++; $display("FAIL latency_8n1: got %0d required %0d",
                rise_cyc_a - (fall_cyc + 1), 2 + (BAUD / 2 + 2) + 9 * BAUD); end
        n_vec++; if (dv_cnt_a - dv0 !== 1) begin
            n_bad++; $display("FAIL valid_width_8n1: got %0d cycles required 1", dv_cnt_a - dv0); end
        got = (words_a.size() > 0) ? words_a.pop_front() : 12'hFFF;
        n_vec++; if (got !== 12'h0A5) begin
            n_bad++; $display("FAIL word_a5: got %h required 0a5", got); end
        n_vec++; if (leds_a !== 8'hA5) begin
            n_bad++; $display("FAIL leds_a5: got %h required a5", leds_a); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] got0, got1;
        words_a.delete();
        send_frame(1'b0, 9'h000, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1);
        send_frame(1'b0, 9'h0FF, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1);
        steps(4);
        got0 = (words_a.size() > 0) ? words_a.pop_front() : 12'hFFF;
        got1 = (words_a.size() > 0) ? words_a.pop_front() : 12'hFFF;
        n_vec++; if (got0 !== 12'h000) begin
            n_bad++; $display("FAIL b2b_word0: got %h required 000", got0); end
        n_vec++; if (got1 !== 12'h0FF) begin
            n_bad++; $display("FAIL b2b_word1: got %h required 0ff", got1); end
        n_vec++; if (brk_cnt_a !== 0) begin
            n_bad++; $display("FAIL b2b_no_break: got %0d pulses required 0", brk_cnt_a); end
    endtask

    task automatic test_false_start();
        int dv0;
        dv0 = dv_cnt_a;
        $display("glitch dut=A low for 4 cycles");
        rx_a = 1'b0; steps(4);
        rx_a = 1'b1; steps(2);
        n_vec++; if (busy_a !== 1'b1) begin
            n_bad++; $display("FAIL false_start_busy: got %b required 1", busy_a); end
        steps(10);
        n_vec++; if (busy_a !== 1'b0) begin
            n_bad++; $display("FAIL false_start_idle: got %b required 0", busy_a); end
        steps(BAUD * 4);
        n_vec++; if (dv_cnt_a - dv0 !== 0) begin
            n_bad++; $display("FAIL false_start_valid: got %0d cycles required 0", dv_cnt_a - dv0); end
    endtask

    task automatic test_noise();
        logic [11:0] got;
        int spike_bits[2] = '{0, 3};
        foreach (spike_bits[k]) begin
            words_a.delete();
            send_frame(1'b0, 9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, spike_bits[k]);
            steps(4);
            got = (words_a.size() > 0) ? words_a.pop_front() : 12'hFFF;
            n_vec++; if (got !== 12'h03C) begin
                n_bad++; $display("FAIL noise_bit%0d: got %h required 03c", spike_bits[k], got); end
        end
    endtask

    task automatic test_overrun();
        int ovr0;
        logic [11:0] got;
        words_a.delete();
        ovr0 = ovr_cnt_a;
        data_ready_a = 1'b0;
        send_frame(1'b0, 9'h011, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1);
        send_frame(1'b0, 9'h022, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1);
        steps(4);
        n_vec++; if (ovr_cnt_a - ovr0 !== 1) begin
            n_bad++; $display("FAIL overrun_pulse: got %0d cycles required 1", ovr_cnt_a - ovr0); end
        n_vec++; if ({data_valid_a, data_out_a} !== 9'h111) begin
            n_bad++; $display("FAIL overrun_hold: got %h required 111", {data_valid_a, data_out_a}); end
        data_ready_a = 1'b1;
        step();
        n_vec++; if ({data_valid_a, leds_a} !== 9'h011) begin
            n_bad++; $display("FAIL overrun_accept: got %h required 011", {data_valid_a, leds_a}); end
        got = (words_a.size() > 0) ? words_a.pop_front() : 12'hFFF;
        n_vec++; if (got !== 12'h011) begin
            n_bad++; $display("FAIL overrun_word: got %h required 011", got); end
    endtask

    task automatic test_break();
        int brk0, dv0;
        logic [11:0] got;
        brk0 = brk_cnt_a; dv0 = dv_cnt_a;
        $display("break dut=A low for %0d cycles", 20 * BAUD);
        rx_a = 1'b0;
        steps(20 * BAUD);
        n_vec++; if (busy_a !== 1'b1) begin
            n_bad++; $display("FAIL break_wait_hi: got busy %b required 1", busy_a); end
        rx_a = 1'b1;
        steps(4);
        n_vec++; if (busy_a !== 1'b0) begin
            n_bad++; $display("FAIL break_recover: got busy %b required 0", busy_a); end
        n_vec++; if (brk_cnt_a - brk0 !== 1) begin
            n_bad++; $display("FAIL break_pulse: got %0d cycles required 1", brk_cnt_a - brk0); end
        n_vec++; if (dv_cnt_a - dv0 !== 0) begin
            n_bad++; $display("FAIL break_no_valid: got %0d cycles required 0", dv_cnt_a - dv0); end
        words_a.delete();
        send_frame(1'b0, 9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1);
        steps(4);
        got = (words_a.size() > 0) ? words_a.pop_front() : 12'hFFF;
        n_vec++; if (got !== 12'h05A) begin
            n_bad++; $display("FAIL break_next_word: got %h required 05a", got); end
    endtask

    task automatic test_7e2();
        int fall_cyc;
        logic [11:0] got;
        words_b.delete();
        // 0x55 has four ones: even parity bit is 0, send 1; both stops low
        send_frame(1'b1, 9'h055, 7, 1'b1, 1'b1, 1'b0, 1'b0, 2, -1);
        steps(20);
        got = (words_b.size() > 0) ? words_b.pop_front() : 12'hFFF;
        n_vec++; if (got !== 12'h655) begin
            n_bad++; $display("FAIL 7e2_bad_frame: got %h required 655", got); end
        n_vec++; if (busy_b !== 1'b1) begin
            n_bad++; $display("FAIL 7e2_wait_hi: got busy %b required 1", busy_b); end
        rx_b = 1'b1;
        steps(4);
        n_vec++; if (busy_b !== 1'b0) begin
            n_bad++; $display("FAIL 7e2_line_high: got busy %b required 0", busy_b); end
        // 0x2A has three ones: even parity bit is 1
        fall_cyc = cyc;
        send_frame(1'b1, 9'h02A, 7, 1'b1, 1'b1, 1'b1, 1'b1, 2, -1);
        steps(4);
        got = (words_b.size() > 0) ? words_b.pop_front() : 12'hFFF;
        n_vec++; if (got !== 12'h02A) begin
            n_bad++; $display("FAIL 7e2_good_frame: got %h required 02a", got); end
        n_vec++; if (rise_cyc_b - (fall_cyc + 1) !== 2 + (BAUD / 2 + 2) + 10 * BAUD) begin
            n_bad++; $display("FAIL latency_7e2: got %0d required %0d",
                rise_cyc_b - (fall_cyc + 1), 2 + (BAUD / 2 + 2) + 10 * BAUD); end
        n_vec++; if (leds_b !== 8'h2A) begin
            n_bad++; $display("FAIL 7e2_leds: got %h required 2a", leds_b); end
    endtask

    task automatic test_reset_mid_frame();
        int brk0, ovr0;
        logic [11:0] got;
        logic [7:0]  partial = 8'hC3;
        brk0 = brk_cnt_a; ovr0 = ovr_cnt_a;
        words_a.delete();
        $display("frame dut=A data=0xc3 aborted by reset after 4 data bits");
        send_bit(1'b0, 1'b0, -1);
        for (int i = 0; i < 4; i++) send_bit(1'b0, partial[i], -1);
        rst = 1'b1; rx_a = 1'b1;
        steps(2);
        n_vec++; if ({data_valid_a, busy_a, parity_err_a, frame_err_a, data_out_a, leds_a} !== 20'h0) begin
            n_bad++; $display("FAIL midframe_reset: got %h required 0",
                {data_valid_a, busy_a, parity_err_a, frame_err_a, data_out_a, leds_a}); end
        rst = 1'b0;
        steps(2 * BAUD);
        n_vec++; if ({brk_cnt_a - brk0, ovr_cnt_a - ovr0} !== {32'd0, 32'd0}) begin
            n_bad++; $display("FAIL midframe_pulses: got brk %0d ovr %0d required 0 0",
                brk_cnt_a - brk0, ovr_cnt_a - ovr0); end
        send_frame(1'b0, 9'h096, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1);
        steps(4);
        got = (words_a.size() > 0) ? words_a.pop_front() : 12'hFFF;
        n_vec++; if (got !== 12'h096) begin
            n_bad++; $display("FAIL post_reset_word: got %h required 096", got); end
        n_vec++; if (leds_a !== 8'h96) begin
            n_bad++; $display("FAIL post_reset_leds: got %h required 96", leds_a); end
    endtask

    initial begin
        dv_cnt_a = 0; brk_cnt_a = 0; ovr_cnt_a = 0; rise_cyc_a = 0; rise_cyc_b = 0;
        test_reset();
        test_timing_8n1();
        test_back_to_back();
        test_false_start();
        test_noise();
        test_overrun();
        test_break();
        test_7e2();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver for the FPGA side of the Pi link. It generalises the fixed 8N1 receiver with:
- configurable data width, parity and stop bits;
- a 2-flop input synchroniser and 3-sample majority voting;
- false-start rejection;
- parity, framing, break and overrun detection;
- a valid/ready output handshake.

It sits between the `rx` pin and the command decoder. `leds` mirrors the last delivered byte.

## Interface
- `BAUD_DIV`, 434, clocks per bit (115200 baud at 50 MHz); legal range ≥ 8
- `DATA_BITS`, 8, data bits per frame; legal 5..9
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even
- `STOP_BITS`, 1, legal 1 or 2
- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `rx` in 1: asynchronous serial input, idle high
- `data_out` out DATA_BITS: received word, LSB first on the line
- `data_valid` out 1: word held; stays high until accepted
- `data_ready` in 1: consumer accepts when `data_valid && data_ready`
- `parity_err` out 1: qualifies `data_out`; valid while `data_valid`
- `frame_err` out 1: qualifies `data_out`; valid while `data_valid`
- `break_det` out 1: one-cycle pulse
- `overrun_err` out 1: one-cycle pulse
- `busy` out 1: FSM not in IDLE
- `leds` out 8: last accepted `data_out`, zero-extended or truncated to 8 bits

## Operation
- **Input path:** `rx` passes through 2 flops, giving `rx_s`, which is preset to 1 on reset. All logic uses `rx_s`.
- **Bit sampling:** a per-bit down-counter runs from `BAUD_DIV-1` to 0. Samples are taken at counter = 2, 1, 0; bit value = majority of the three.
- **FSM states:** IDLE, START, DATA, PAR, STOP, WAIT_HI.
- **IDLE:** on `rx_s == 0`, go to START and load the counter with `BAUD_DIV/2 + 1`, so the vote centres on mid-start.
- **START:** if the voted bit is 1 (false start), return to IDLE and drop nothing. Otherwise go to DATA, clear the bit index and reload `BAUD_DIV-1`.
- **DATA:** shift the voted bit into the MSB of the shift register (LSB-first framing). After `DATA_BITS` bits, go to PAR if `PARITY != 0`, else STOP.
- **PAR:** `parity_err` = XOR(data bits, parity bit) ≠ (`PARITY == 1`).
- **STOP:** sample `STOP_BITS` bits. `frame_err` is set if any stop bit is 0.
- **End of frame:**
  - **Break:** data all 0, parity bit 0 if present, and first stop bit 0. Pulse `break_det`, do not deliver a word, go to WAIT_HI.
  - **Otherwise, consumer free** (`data_valid` low, or accepted in the same cycle): load `data_out`/`parity_err`/`frame_err`, set `data_valid`.
  - **Otherwise, holding register still occupied:** pulse `overrun_err` and discard the new word. The old word is kept.
  - **Next state:** if the last stop bit sampled is 0, go to WAIT_HI; else IDLE.
- **WAIT_HI:** stay until `rx_s == 1`, then go to IDLE. This prevents retriggering during a break or line fault.
- **Accept:** on `data_valid && data_ready`, clear `data_valid`, copy `data_out` to `leds`.

## Timing
- **Reset values:** all outputs 0; FSM in IDLE; counter and bit index 0; `rx_s` = 1.
- **Reset mid-frame:** abort immediately. No `data_valid`, no error pulse.
- **Start detect:** 2 cycles after the `rx` falling edge (synchroniser).
- **Delivery:** `data_valid` rises exactly `2 + (BAUD_DIV/2+2) + (DATA_BITS + P + STOP_BITS)·BAUD_DIV` cycles after the `rx` falling edge, where P = (`PARITY != 0`). Confirm against an RTL count once; the formula is normative.
- **Back-to-back frames:** a new start bit is accepted the cycle after leaving STOP.
- **Simultaneous accept and new word:** the new word loads, `data_valid` stays high, and `leds` takes the old word.
- **Pulse outputs:** `break_det` and `overrun_err` are high for exactly 1 cycle.

## Structure
- **Package `uart_pkg`:** `parity_e` enum (NONE, ODD, EVEN) and `rx_state_e` enum.
- **Sub-module `uart_rx_sampler`:** 2-flop synchroniser plus 3-sample majority register. Outputs `rx_s` and `bit_vote`.
- **Elaboration check:** an assertion enforces the legal parameter ranges.

## Test plan
- **8N1, `BAUD_DIV` = 16:** frame 0xA5, `data_ready` = 1 → `data_valid` for 1 cycle, `data_out` = 0xA5, `leds` = 0xA5, no error flags.
- **7E2:** frame 0x55 with wrong parity bit → `parity_err` = 1. Stop bits low → `frame_err` = 1, then WAIT_HI until the line goes high.
- **False start:** 4-cycle low glitch on `rx` → no `data_valid`, `busy` back to 0 by mid-start.
- **Single-sample noise:** 1-cycle spike at a bit centre of 0x3C → still 0x3C (majority vote).
- **Overrun:** `data_ready` = 0, two frames 0x11 then 0x22 → `overrun_err` pulse, `data_out` stays 0x11. Then `data_ready` = 1 → `leds` = 0x11.
- **Break and reset:** `rx` low for 2 frame times → one `break_det` pulse, no `data_valid`, recovery after `rx` goes high. Separately, `rst` mid-DATA → all outputs 0, next frame received correctly.
